// File: rtl/i2c_reg_arbiter.sv
// Round-robin arbiter that lets several host ports share one register-file access
// channel. It handles one transaction at a time and times out if reg_ack never arrives.
module i2c_reg_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    host_valid,
    input  logic [NUM_PORTS-1:0]    host_we,
    input  logic [NUM_PORTS*AW-1:0] host_addr,
    input  logic [NUM_PORTS*DW-1:0] host_wdata,
    output logic [NUM_PORTS-1:0]    host_ready,
    output logic [NUM_PORTS-1:0]    host_rvalid,
    output logic [DW-1:0]           host_rdata,
    output logic                    host_err,
    output logic                    reg_en,
    output logic                    reg_we,
    output logic [AW-1:0]           reg_addr,
    output logic [DW-1:0]           reg_wdata,
    input  logic [DW-1:0]           reg_rdata,
    input  logic                    reg_ack
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] grant;
    logic [GW-1:0] sel;
    logic          any_valid;
    logic [15:0]   wait_cnt;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    // Scan from farthest to nearest so that the port closest after last_grant wins.
    always_comb begin
        sel       = last_grant;
        any_valid = 1'b0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            int idx;
            idx = (int'(last_grant) + i) % NUM_PORTS;
            if (host_valid[idx]) begin
                sel       = GW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_PORTS - 1);
            grant      <= '0;
            wait_cnt   <= '0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant     <= sel;
                        cap_we    <= host_we[sel];
                        cap_addr  <= host_addr[int'(sel)*AW +: AW];
                        cap_wdata <= host_wdata[int'(sel)*DW +: DW];
                        wait_cnt  <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack in the final wait cycle beats the timeout.
                    if (reg_ack) begin
                        rdata_q <= cap_we ? '0 : reg_rdata;
                        err_q   <= 1'b0;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt == WaitLast) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        host_ready  = '0;
        host_rvalid = '0;
        host_rdata  = '0;
        host_err    = 1'b0;
        reg_en      = 1'b0;
        reg_we      = 1'b0;
        reg_addr    = '0;
        reg_wdata   = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (any_valid) host_ready[sel] = 1'b1;
                end
                ACCESS: begin
                    reg_en    = 1'b1;
                    reg_we    = cap_we;
                    reg_addr  = cap_addr;
                    reg_wdata = cap_wdata;
                end
                RESP: begin
                    host_rvalid[grant] = 1'b1;
                    host_rdata         = rdata_q;
                    host_err           = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Randomized bench for i2c_reg_arbiter: a transaction-level model predicts the grant,
// the access window length and the response for every request.
module tb_i2c_reg_arbiter;

    localparam int NP = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    host_valid, host_we, host_ready, host_rvalid;
    logic [NP*AW-1:0] host_addr;
    logic [NP*DW-1:0] host_wdata;
    logic [DW-1:0]    host_rdata, reg_wdata, reg_rdata;
    logic             host_err, reg_en, reg_we, reg_ack;
    logic [AW-1:0]    reg_addr;

    int checks = 0;
    int errors = 0;

    // Model state: pending request per port and the last port served.
    bit            pv[NP];
    bit            pwe[NP];
    logic [AW-1:0] pa[NP];
    logic [DW-1:0] pd[NP];
    int            last_g;

    always #5 clk = ~clk;

    i2c_reg_arbiter #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .host_valid (host_valid),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ready (host_ready),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .host_err   (host_err),
        .reg_en     (reg_en),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick();
        for (int i = 1; i <= NP; i++) begin
            int p;
            p = (last_g + i) % NP;
            if (pv[p]) return p;
        end
        return -1;
    endfunction

    task automatic drive_hosts();
        for (int p = 0; p < NP; p++) begin
            host_valid[p]          = pv[p];
            host_we[p]             = pwe[p];
            host_addr[p*AW +: AW]  = pa[p];
            host_wdata[p*DW +: DW] = pd[p];
        end
    endtask

    task automatic set_req(input int p, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        pv[p] = 1'b1; pwe[p] = we; pa[p] = a; pd[p] = d;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int p = 0; p < NP; p++) pv[p] = 1'b0;
        drive_hosts();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        last_g = NP - 1;
        @(negedge clk);
    endtask

    // Entered at a negedge while the DUT is idle; d = wait cycles before ack (>= TO: none).
    task automatic run_txn(input int d, input logic [DW-1:0] rd, output int g);
        bit            we;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        int            n;
        drive_hosts();
        #1;
        g = pick();
        check_eq("idle_rvalid", host_rvalid, 0);
        check_eq("idle_rdata", host_rdata, 0);
        check_eq("idle_reg_en", reg_en, 0);
        check_eq("grant", host_ready, 64'(1) << g);
        we = pwe[g]; ea = pa[g]; ew = pd[g];
        pv[g] = 1'b0;
        n = (d < TO) ? d + 1 : TO;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            drive_hosts();
            reg_ack   = (k == d + 1);
            reg_rdata = (k == d + 1) ? rd : $urandom;
            #1;
            check_eq("reg_en", reg_en, 1);
            check_eq("reg_we", reg_we, we);
            check_eq("reg_addr", reg_addr, ea);
            check_eq("reg_wdata", reg_wdata, ew);
            check_eq("busy_ready", host_ready, 0);
            check_eq("busy_rvalid", host_rvalid, 0);
        end
        @(negedge clk);
        reg_ack   = 1'($urandom_range(0, 1));
        reg_rdata = $urandom;
        #1;
        check_eq("rvalid", host_rvalid, 64'(1) << g);
        check_eq("rdata", host_rdata, (d < TO && !we) ? rd : 0);
        check_eq("err", host_err, (d >= TO) ? 1 : 0);
        check_eq("resp_reg_en", reg_en, 0);
        check_eq("resp_ready", host_ready, 0);
        last_g = g;
        @(negedge clk);
        reg_ack = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int g;
        int exp_order[4] = '{0, 1, 2, 0};
        rst        = 1'b1;
        host_valid = '1;
        host_we    = '0;
        host_addr  = '0;
        host_wdata = '0;
        reg_rdata  = '1;
        reg_ack    = 1'b1;
        last_g     = NP - 1;
        for (int p = 0; p < NP; p++) begin
            pv[p] = 1'b0; pwe[p] = 1'b0; pa[p] = '0; pd[p] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ready", host_ready, 0);
        check_eq("rst_rvalid", host_rvalid, 0);
        check_eq("rst_rdata", host_rdata, 0);
        check_eq("rst_err", host_err, 0);
        check_eq("rst_reg_en", reg_en, 0);
        check_eq("rst_reg_bus", {reg_we, reg_addr, reg_wdata}, 0);
        apply_reset();
        reg_ack = 1'b0;

        // Single read, ack in the first access cycle.
        set_req(1, 1'b0, 8'h04, $urandom);
        run_txn(0, 32'h0000_00A5, g);

        // Contention from reset: all ports request continuously.
        apply_reset();
        for (int p = 0; p < NP; p++) set_req(p, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        for (int t = 0; t < 4; t++) begin
            run_txn($urandom_range(0, 2), $urandom, g);
            check_eq("rr_order", g, exp_order[t]);
            set_req(g, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        end

        // Stalled write ack (lands on the last allowed cycle), timeout, and read ack at the limit.
        for (int p = 0; p < NP; p++) pv[p] = 1'b0;
        set_req(0, 1'b1, 8'h10, 32'h3C);
        run_txn(5, $urandom, g);
        set_req(2, 1'b0, 8'h20, $urandom);
        run_txn(TO + 3, $urandom, g);
        set_req(1, 1'b0, 8'h30, $urandom);
        run_txn(TO - 1, 32'h55, g);

        // Reset two cycles into an access: no response, priority restarts at port 0.
        set_req(1, 1'b0, 8'h44, $urandom);
        set_req(2, 1'b1, 8'h48, $urandom);
        drive_hosts();
        #1;
        check_eq("pre_rst_grant", host_ready, 64'(1) << pick());
        pv[pick()] = 1'b0;
        @(negedge clk);
        drive_hosts();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_reg_en", reg_en, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < NP; p++) pv[p] = 1'b0;
        drive_hosts();
        last_g  = NP - 1;
        reg_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("post_rst_rvalid", host_rvalid, 0);
            check_eq("post_rst_reg_en", reg_en, 0);
            @(negedge clk);
        end
        reg_ack = 1'b0;
        set_req(0, 1'b0, 8'h50, $urandom);
        set_req(2, 1'b0, 8'h54, $urandom);
        run_txn(1, $urandom, g);
        check_eq("post_rst_first", g, 0);

        // Random traffic.
        for (int t = 0; t < 150; t++) begin
            int cnt;
            cnt = 0;
            for (int p = 0; p < NP; p++) begin
                if (!pv[p] && $urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
                if (pv[p]) cnt++;
            end
            if (cnt > 1 && $urandom_range(0, 7) == 0) pv[$urandom_range(0, NP - 1)] = 1'b0;
            if (pick() < 0) set_req($urandom_range(0, NP - 1), 1'b0, AW'($urandom), $urandom);
            run_txn($urandom_range(0, TO + 1), $urandom, g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
